seq_word_scanner: RTL
=====================

# seq_word_scanner

Sequencing controller for the serial "1011" Moore pattern detector. It accepts parallel words over a valid/ready handshake and shifts each word MSB-first into an embedded detector, one bit per cycle. It counts non-overlapping matches and returns a per-word match count over a second valid/ready handshake. It sits between a word-oriented producer and the bit-serial detection logic, replacing per-bit `valid` strobing by the producer.

## Interface
- `WIDTH`, default 8: bits per input word; must be ≥ 4.
- `CNT_W`, default 4: match-count width; the count saturates at 2^CNT_W−1.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  producer has a word on `in_data`.
- `in_ready`  out  1  scanner can accept a word.
- `in_data`  in  WIDTH  word to scan; bit WIDTH−1 is scanned first.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result.
- `out_count`  out  CNT_W  number of matches in the scanned word.
- `out_hit`  out  1  `out_count` ≠ 0.
- `busy`  out  1  high in the SHIFT and DONE states.

## Operation
- Controller FSM states: IDLE, SHIFT, DONE.
  - IDLE: `in_ready`=1. When `in_valid`=1, the word is loaded into the shift register, the bit counter is cleared, the match count is cleared, and the FSM goes to SHIFT.
  - SHIFT: each cycle the detector consumes `sreg[WIDTH-1]` and the shift register shifts left. After WIDTH bits have been consumed, the FSM goes to DONE.
  - DONE: `out_valid`=1. `out_count` and `out_hit` are held stable. When `out_ready`=1, the FSM goes to IDLE.
- Detector states: A, B, C, D, E (one-hot); pattern 1011; non-overlapping.
  - A: 1→B, 0→A.
  - B: 1→B, 0→C.
  - C: 1→D, 0→A.
  - D: 1→E, 0→C.
  - E: same transitions as A (1→B, 0→A).
- The match count increments on every transition into E, and saturates at 2^CNT_W−1.
- `in_valid` is ignored outside IDLE. `in_data` is sampled only on the accepting edge.
- A match completed by the last bit of a word is included in that word's count.
- A reset while in SHIFT or DONE discards the word and its result. The word is not replayed.

## Timing
- Reset values: FSM=IDLE; detector=A; count=0; `in_ready`=1; `out_valid`=0; `out_count`=0; `out_hit`=0; `busy`=0; shift register=0.
- Word accepted at edge 0 → bits are consumed at edges 1..WIDTH → `out_valid` rises after edge WIDTH.
- DONE→IDLE occurs on the edge where `out_valid`&&`out_ready`. `in_ready` rises in the following cycle.
- Minimum period per word: WIDTH+2 cycles. There is no overlap of accept and result.
- `out_ready` held low stalls the FSM in DONE indefinitely. All outputs are held stable during the stall.

## Configuration
- Macro: `SEQ_CARRY_EN`.
- Defined: the detector state persists across words, so a pattern spanning a word boundary is counted in the word containing its final bit. The detector returns to A only on reset.
- Undefined: the detector is forced to A on every word accept, and each word is scanned independently.
- In both cases the match count clears on every accept.

## Test plan
- Basic match: reset, then send `8'b1011_1011` → after 9 edges `out_valid`=1, `out_count`=2, `out_hit`=1.
- Non-overlap: send `8'b1011_0110` → `out_count`=1 (an overlapping detector would report 2). Send `8'b0000_0000` → `out_count`=0, `out_hit`=0.
- Word-boundary carry: send `8'b0000_0010`, then `8'b1100_0000` → first word `out_count`=0. Second word `out_count`=1 with `SEQ_CARRY_EN` defined, 0 without it.
- Backpressure: after `out_valid` rises, hold `out_ready`=0 for 5 cycles while pulsing `in_valid` → `out_count` stays stable, `in_ready`=0, and the second word is not accepted. Raise `out_ready` → `in_ready`=1 in the next cycle.
- Saturation: with CNT_W=1, send `8'b1011_1011` → `out_count`=1, `out_hit`=1.
- Reset mid-operation: assert `rst`=0 asynchronously at the 3rd SHIFT cycle → all outputs immediately take their reset values. A subsequent `8'b1011_0000` yields `out_count`=1, with no carried detector state in either configuration.

Source files
------------

// File: rtl/seq_word_scanner.sv
// Word-to-bit sequencer around a "1011" non-overlapping Moore detector; returns per-word match counts.
// Optional SEQ_CARRY_EN: detector state persists across words instead of restarting at A on each accept.
module seq_word_scanner #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic             out_hit,
    output logic             busy
);

    localparam int unsigned       BCNT_W   = $clog2(WIDTH);
    localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    localparam logic [4:0] DET_A = 5'b00001;
    localparam logic [4:0] DET_B = 5'b00010;
    localparam logic [4:0] DET_C = 5'b00100;
    localparam logic [4:0] DET_D = 5'b01000;
    localparam logic [4:0] DET_E = 5'b10000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [WIDTH-1:0]   r_sreg, w_sreg_nxt;
    logic [BCNT_W-1:0]  r_bitcnt, w_bitcnt_nxt;
    logic [4:0]         r_det, w_det_nxt, w_det_step;
    logic [CNT_W-1:0]   r_count, w_count_nxt;
    logic               r_in_ready, w_in_ready_nxt;
    logic               r_out_valid, w_out_valid_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_hit, w_hit_nxt;

    // One detector step; E restarts like A so matches never overlap.
    function automatic logic [4:0] det_step(input logic [4:0] det, input logic b);
        logic [4:0] nxt;
        nxt = DET_A;
        unique case (det)
            DET_A, DET_E: nxt = b ? DET_B : DET_A;
            DET_B:        nxt = b ? DET_B : DET_C;
            DET_C:        nxt = b ? DET_D : DET_A;
            DET_D:        nxt = b ? DET_E : DET_C;
            default:      nxt = DET_A;
        endcase
        return nxt;
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_sreg      <= '0;
            r_bitcnt    <= '0;
            r_det       <= DET_A;
            r_count     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_hit       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sreg      <= w_sreg_nxt;
            r_bitcnt    <= w_bitcnt_nxt;
            r_det       <= w_det_nxt;
            r_count     <= w_count_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_busy      <= w_busy_nxt;
            r_hit       <= w_hit_nxt;
        end
    end

    // Next-state and datapath update
    always_comb begin
        w_state_nxt  = r_state;
        w_sreg_nxt   = r_sreg;
        w_bitcnt_nxt = r_bitcnt;
        w_det_nxt    = r_det;
        w_count_nxt  = r_count;
        w_det_step   = det_step(r_det, r_sreg[WIDTH-1]);
        unique case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_nxt  = S_SHIFT;
                    w_sreg_nxt   = in_data;
                    w_bitcnt_nxt = '0;
                    w_count_nxt  = '0;
`ifdef SEQ_CARRY_EN
                    w_det_nxt    = r_det;
`else
                    w_det_nxt    = DET_A;
`endif
                end
            end
            S_SHIFT: begin
                w_det_nxt    = w_det_step;
                w_sreg_nxt   = {r_sreg[WIDTH-2:0], 1'b0};
                w_bitcnt_nxt = r_bitcnt + 1'b1;
                if (w_det_step == DET_E && r_count != CNT_MAX) begin
                    w_count_nxt = r_count + 1'b1;
                end
                if (r_bitcnt == LAST_BIT) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode, registered alongside the state
    always_comb begin
        w_in_ready_nxt  = 1'b0;
        w_out_valid_nxt = 1'b0;
        w_busy_nxt      = 1'b0;
        w_hit_nxt       = |w_count_nxt;
        unique case (w_state_nxt)
            S_IDLE:  w_in_ready_nxt  = 1'b1;
            S_SHIFT: w_busy_nxt      = 1'b1;
            S_DONE: begin
                w_out_valid_nxt = 1'b1;
                w_busy_nxt      = 1'b1;
            end
            default: w_in_ready_nxt  = 1'b1;
        endcase
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_count = r_count;
    assign out_hit   = r_hit;
    assign busy      = r_busy;

endmodule
